// File: rtl/wb_commit_pkg.sv
// Shared register-bus types and control constants for the write-back commit slice.
package wb_commit_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;

    localparam RegBus     ZeroWord     = 32'h0000_0000;
    localparam RegAddrBus NOPRegAddr   = 5'b00000;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam logic      ReadEnable   = 1'b1;
    localparam logic      ReadDisable  = 1'b0;
    localparam logic      RstEnable    = 1'b1;

endpackage

// File: rtl/wb_regfile.sv
// General-purpose register file: one write port, two combinational read ports.
// WB_COMMIT_BYPASS_EN forwards the in-flight write onto matching reads.
module wb_regfile
    import wb_commit_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [4:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re1,
    input  logic [4:0]    raddr1,
    input  logic          re2,
    input  logic [4:0]    raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    localparam int AW = $clog2(NREG);

    logic [DW-1:0] r_gpr [NREG];
    logic [DW-1:0] w_rdata1;
    logic [DW-1:0] w_rdata2;

    // Register array: cleared on reset, register 0 never written.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (we == WriteEnable && waddr != NOPRegAddr) begin
            r_gpr[waddr[AW-1:0]] <= wdata;
        end else begin
            r_gpr <= r_gpr;
        end
    end

    // Read port 1.
    always_comb begin
        w_rdata1 = '0;
        if (rst == RstEnable || re1 == ReadDisable || raddr1 == NOPRegAddr) begin
            w_rdata1 = '0;
`ifdef WB_COMMIT_BYPASS_EN
        end else if (we == WriteEnable && waddr == raddr1) begin
            w_rdata1 = wdata;
`endif
        end else begin
            w_rdata1 = r_gpr[raddr1[AW-1:0]];
        end
    end

    // Read port 2.
    always_comb begin
        w_rdata2 = '0;
        if (rst == RstEnable || re2 == ReadDisable || raddr2 == NOPRegAddr) begin
            w_rdata2 = '0;
`ifdef WB_COMMIT_BYPASS_EN
        end else if (we == WriteEnable && waddr == raddr2) begin
            w_rdata2 = wdata;
`endif
        end else begin
            w_rdata2 = r_gpr[raddr2[AW-1:0]];
        end
    end

    assign rdata1 = w_rdata1;
    assign rdata2 = w_rdata2;

endmodule

// File: rtl/wb_commit.sv
// Write-back commit stage: GPR file, HI/LO pair, LLbit and retired-write counter.
// WB_COMMIT_BYPASS_EN makes same-cycle writes visible on all outputs.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_wreg,
    input  logic [4:0]    wb_wd,
    input  logic [DW-1:0] wb_wdata,
    input  logic          wb_whilo,
    input  logic [DW-1:0] wb_hi,
    input  logic [DW-1:0] wb_lo,
    input  logic          wb_LLbit_we,
    input  logic          wb_LLbit_value,
    input  logic          flush,
    input  logic          re1,
    input  logic          re2,
    input  logic [4:0]    raddr1,
    input  logic [4:0]    raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic          LLbit_o,
    output logic [31:0]   retire_cnt
);

    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;
    logic          r_llbit;
    logic          w_llbit_next;
    RegBus         r_retire_cnt;

    wb_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_wreg),
        .waddr  (wb_wd),
        .wdata  (wb_wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // HI and LO always move as a pair.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (wb_whilo == WriteEnable) begin
            r_hi <= wb_hi;
            r_lo <= wb_lo;
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    // LLbit next value: reset, then flush, then explicit write.
    always_comb begin
        w_llbit_next = r_llbit;
        if (rst == RstEnable) begin
            w_llbit_next = 1'b0;
        end else if (flush == 1'b1) begin
            w_llbit_next = 1'b0;
        end else if (wb_LLbit_we == WriteEnable) begin
            w_llbit_next = wb_LLbit_value;
        end else begin
            w_llbit_next = r_llbit;
        end
    end

    // LLbit state register.
    always_ff @(posedge clk) begin
        r_llbit <= w_llbit_next;
    end

    // Counts every committed GPR write, including discarded writes to register 0.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_retire_cnt <= ZeroWord;
        end else if (wb_wreg == WriteEnable) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end else begin
            r_retire_cnt <= r_retire_cnt;
        end
    end

`ifdef WB_COMMIT_BYPASS_EN
    assign hi_o    = (rst != RstEnable && wb_whilo == WriteEnable) ? wb_hi : r_hi;
    assign lo_o    = (rst != RstEnable && wb_whilo == WriteEnable) ? wb_lo : r_lo;
    assign LLbit_o = w_llbit_next;
`else
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign LLbit_o = r_llbit;
`endif

    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: stimulus queues expected values, a negedge monitor checks them.
module tb_wb_commit;

    logic        clk;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        flush;
    logic        re1;
    logic        re2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;
    logic [31:0] retire_cnt;

    localparam int S_R1 = 0, S_R2 = 1, S_HI = 2, S_LO = 3, S_LL = 4, S_CNT = 5;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

`ifdef WB_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_commit #(.DW(32), .NREG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_wreg        (wb_wreg),
        .wb_wd          (wb_wd),
        .wb_wdata       (wb_wdata),
        .wb_whilo       (wb_whilo),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_LLbit_we    (wb_LLbit_we),
        .wb_LLbit_value (wb_LLbit_value),
        .flush          (flush),
        .re1            (re1),
        .re2            (re2),
        .raddr1         (raddr1),
        .raddr2         (raddr2),
        .rdata1         (rdata1),
        .rdata2         (rdata2),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .LLbit_o        (LLbit_o),
        .retire_cnt     (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_now(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drain every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                S_R1:    act = rdata1;
                S_R2:    act = rdata2;
                S_HI:    act = hi_o;
                S_LO:    act = lo_o;
                S_LL:    act = {31'd0, LLbit_o};
                S_CNT:   act = retire_cnt;
                default: act = 32'hxxxx_xxxx;
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'd0;
        wb_whilo = 1'b0; wb_hi = 32'd0; wb_lo = 32'd0;
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        tick();
        tick();

        // Reset state
        rst = 1'b0; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd7;
        expect_now(S_R1, 32'd0, "rst_r1");
        expect_now(S_R2, 32'd0, "rst_r2");
        expect_now(S_HI, 32'd0, "rst_hi");
        expect_now(S_LO, 32'd0, "rst_lo");
        expect_now(S_LL, 32'd0, "rst_ll");
        expect_now(S_CNT, 32'd0, "rst_cnt");
        tick();

        // Write r5
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        expect_now(S_R1, BYP ? 32'hDEAD_BEEF : 32'd0, "w5_same_cycle");
        expect_now(S_CNT, 32'd0, "w5_cnt_before");
        tick();

        // Write r0 (discarded), read back r5
        wb_wd = 5'd0; wb_wdata = 32'h0000_1234; raddr1 = 5'd0; raddr2 = 5'd5;
        expect_now(S_R1, 32'd0, "r0_read_zero");
        expect_now(S_R2, 32'hDEAD_BEEF, "r5_after_edge");
        expect_now(S_CNT, 32'd1, "cnt_after_w5");
        tick();

        // Write r7 while reading r7
        wb_wd = 5'd7; wb_wdata = 32'hA5A5_A5A5; raddr1 = 5'd5; raddr2 = 5'd7;
        expect_now(S_R2, BYP ? 32'hA5A5_A5A5 : 32'd0, "w7_same_cycle");
        expect_now(S_R1, 32'hDEAD_BEEF, "r5_hold");
        expect_now(S_CNT, 32'd2, "cnt_after_w0");
        tick();

        wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'd0;
        expect_now(S_R2, 32'hA5A5_A5A5, "r7_after_edge");
        expect_now(S_CNT, 32'd3, "cnt_after_w7");
        tick();

        // HI/LO write; LLbit write loses to flush
        wb_whilo = 1'b1; wb_hi = 32'h0000_0001; wb_lo = 32'h0000_0002;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1; flush = 1'b1;
        expect_now(S_HI, BYP ? 32'd1 : 32'd0, "hi_same_cycle");
        expect_now(S_LO, BYP ? 32'd2 : 32'd0, "lo_same_cycle");
        expect_now(S_LL, 32'd0, "ll_flush_prio");
        tick();

        wb_whilo = 1'b0; wb_hi = 32'hFFFF_FFFF; wb_lo = 32'hFFFF_FFFF; flush = 1'b0; re2 = 1'b0;
        expect_now(S_HI, 32'd1, "hi_after_edge");
        expect_now(S_LO, 32'd2, "lo_after_edge");
        expect_now(S_LL, BYP ? 32'd1 : 32'd0, "ll_write_same_cycle");
        expect_now(S_R2, 32'd0, "re2_disabled");
        tick();

        // Bubble: everything holds
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; re2 = 1'b1;
        expect_now(S_LL, 32'd1, "ll_after_edge");
        expect_now(S_HI, 32'd1, "hi_bubble_hold");
        expect_now(S_LO, 32'd2, "lo_bubble_hold");
        expect_now(S_R2, 32'hA5A5_A5A5, "r7_bubble_hold");
        expect_now(S_CNT, 32'd3, "cnt_bubble_hold");
        tick();

        // Reset dominates every write enable
        rst = 1'b1; wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hFFFF_FFFF;
        wb_whilo = 1'b1; wb_hi = 32'd9; wb_lo = 32'd9;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        expect_now(S_R1, 32'd0, "r1_during_rst");
        expect_now(S_R2, 32'd0, "r2_during_rst");
        tick();

        rst = 1'b0; wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'd0;
        wb_whilo = 1'b0; wb_hi = 32'd0; wb_lo = 32'd0;
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        expect_now(S_R1, 32'd0, "r5_after_rst");
        expect_now(S_R2, 32'd0, "r7_after_rst");
        expect_now(S_HI, 32'd0, "hi_after_rst");
        expect_now(S_LO, 32'd0, "lo_after_rst");
        expect_now(S_LL, 32'd0, "ll_after_rst");
        expect_now(S_CNT, 32'd0, "cnt_after_rst");
        tick();
        tick();
        tick();

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
